// File: rtl/trafficlight_monitor.sv
// Safety monitor and lamp driver behind the traffic-light controller: checks the
// sampled lights for illegal pairs, bad phase order and over-long phases, then drives the lamps.
module trafficlight_monitor #(
    parameter int max_phase = 15
) (
    input  logic       clk_seconds,
    input  logic       reset,
    input  logic [2:0] main_lights,
    input  logic [2:0] sec_lights,
    output logic [2:0] main_out,
    output logic [2:0] sec_out,
    output logic [1:0] phase,
    output logic [4:0] elapsed,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam logic [2:0] green  = 3'b001;
    localparam logic [2:0] yellow = 3'b010;
    localparam logic [2:0] red    = 3'b100;
    localparam logic [4:0] max_elapsed = 5'(max_phase);

    logic       legal;
    logic [1:0] decoded;
    logic [1:0] new_code;
    logic       seen;
    logic       blink;

    always_comb begin
        legal   = 1'b1;
        decoded = 2'd0;
        case ({main_lights, sec_lights})
            {green,  red}:    decoded = 2'd0;
            {yellow, red}:    decoded = 2'd1;
            {red,    green}:  decoded = 2'd2;
            {red,    yellow}: decoded = 2'd3;
            default:          legal   = 1'b0;
        endcase
    end

    // Checks in priority order; the first sample after reset skips the sequence check.
    always_comb begin
        new_code = 2'd0;
        if (!legal) begin
            new_code = 2'd1;
        end else if (seen) begin
            if (decoded == phase) begin
                if (elapsed == max_elapsed) new_code = 2'd3;
            end else if (decoded != phase + 2'd1) begin
                new_code = 2'd2;
            end
        end
    end

    always_ff @(posedge clk_seconds or posedge reset) begin
        if (reset) begin
            main_out   <= red;
            sec_out    <= red;
            phase      <= 2'd0;
            elapsed    <= 5'd0;
            fault      <= 1'b0;
            fault_code <= 2'd0;
            seen       <= 1'b0;
            blink      <= 1'b0;
        end else if (fault) begin
            // Frozen state; only the flashing red keeps running.
            main_out <= blink ? 3'b000 : red;
            sec_out  <= blink ? 3'b000 : red;
            blink    <= ~blink;
        end else if (new_code != 2'd0) begin
            fault      <= 1'b1;
            fault_code <= new_code;
            main_out   <= red;
            sec_out    <= red;
            blink      <= 1'b1;
        end else begin
            main_out <= main_lights;
            sec_out  <= sec_lights;
            if (!seen) begin
                phase   <= decoded;
                elapsed <= 5'd0;
                seen    <= 1'b1;
            end else if (decoded == phase) begin
                elapsed <= elapsed + 5'd1;
            end else begin
                phase   <= decoded;
                elapsed <= 5'd0;
            end
        end
    end

endmodule
